// File: rtl/measure_scheduler.sv
// Measurement sequencer for a ring-oscillator edge counter: settle, average a burst
// of counting windows, hand the result to a UART, then idle for a gap before repeating.
module measure_scheduler #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned WIN_CYCLES    = 256,
  parameter int unsigned AVG_LOG2      = 2,
  parameter int unsigned GAP_CYCLES    = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] count_in,
  input  logic       tx_busy,
  output logic       ro_en,
  output logic       cnt_clr,
  output logic       tx_start,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       sat,
  output logic       busy
);

  localparam int unsigned MAX_A     = (SETTLE_CYCLES > WIN_CYCLES) ? SETTLE_CYCLES : WIN_CYCLES;
  localparam int unsigned MAX_C     = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int unsigned CW        = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam int unsigned IW        = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned AW        = 8 + AVG_LOG2;
  localparam int unsigned LAST_WIN  = (1 << AVG_LOG2) - 1;

  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] WIN_LD    = CW'(WIN_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD    = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(LAST_WIN);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    SEND,
    WAIT_TX,
    GAP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [AW-1:0] acc_q, acc_d;
  logic          sat_acc_q, sat_acc_d;
  logic          stop_q, stop_d;
  logic          ro_en_q, ro_en_d;
  logic          cnt_clr_q, cnt_clr_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    result_q, result_d;
  logic          result_valid_q, result_valid_d;
  logic          sat_q, sat_d;
  logic          busy_q, busy_d;

  logic [AW-1:0] sum;
  logic          is_ff;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    acc_d          = acc_q;
    sat_acc_d      = sat_acc_q;
    stop_d         = stop_q;
    tx_start_d     = tx_start_q;
    result_d       = result_q;
    sat_d          = sat_q;
    cnt_clr_d      = 1'b0;
    result_valid_d = 1'b0;
    sum            = acc_q + AW'(count_in);
    is_ff          = (count_in == 8'hFF);

    unique case (state_q)
      IDLE: begin
        if (run) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LD;
        end
      end
      SETTLE: begin
        if (!run) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d   = MEASURE;
          cnt_clr_d = 1'b1;
          acc_d     = '0;
          idx_d     = '0;
          sat_acc_d = 1'b0;
          cnt_d     = WIN_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MEASURE: begin
        if (!run) begin
          // Abort drops the partial burst; published result/sat are left untouched.
          state_d   = IDLE;
          cnt_d     = '0;
          acc_d     = '0;
          idx_d     = '0;
          sat_acc_d = 1'b0;
        end else if (cnt_q == '0) begin
          if (idx_q == IDX_LAST) begin
            state_d        = SEND;
            result_d       = 8'(sum >> AVG_LOG2);
            sat_d          = sat_acc_q | is_ff;
            result_valid_d = 1'b1;
            tx_start_d     = 1'b1;
            stop_d         = 1'b0;
            acc_d          = '0;
            idx_d          = '0;
            sat_acc_d      = 1'b0;
          end else begin
            acc_d     = sum;
            sat_acc_d = sat_acc_q | is_ff;
            idx_d     = idx_q + IW'(1);
            cnt_clr_d = 1'b1;
            cnt_d     = WIN_LD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SEND: begin
        if (!run) stop_d = 1'b1;
        if (tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (!run) stop_d = 1'b1;
        if (!tx_busy) begin
          stop_d = 1'b0;
          if (stop_q || !run) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            cnt_d   = GAP_LD;
          end
        end
      end
      GAP: begin
        if (!run) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    ro_en_d = (state_d == SETTLE) || (state_d == MEASURE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      acc_q          <= '0;
      sat_acc_q      <= 1'b0;
      stop_q         <= 1'b0;
      ro_en_q        <= 1'b0;
      cnt_clr_q      <= 1'b0;
      tx_start_q     <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      sat_q          <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      acc_q          <= acc_d;
      sat_acc_q      <= sat_acc_d;
      stop_q         <= stop_d;
      ro_en_q        <= ro_en_d;
      cnt_clr_q      <= cnt_clr_d;
      tx_start_q     <= tx_start_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      sat_q          <= sat_d;
      busy_q         <= busy_d;
    end
  end

  assign ro_en        = ro_en_q;
  assign cnt_clr      = cnt_clr_q;
  assign tx_start     = tx_start_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign sat          = sat_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_measure_scheduler.sv
// Self-checking bench for measure_scheduler: cycle-accurate burst timeline, averaging
// and saturation reference, UART handshake, run aborts and asynchronous reset.
module tb_measure_scheduler;

  localparam int SC = 4;
  localparam int WC = 8;
  localparam int AL = 2;
  localparam int GC = 3;
  localparam int NW = 1 << AL;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [7:0] count_in;
  logic       tx_busy;
  logic       ro_en, cnt_clr, tx_start, result_valid, sat, busy;
  logic [7:0] result;

  int vec  = 0;
  int errs = 0;
  logic [7:0] m_result = 8'h00;
  logic       m_sat    = 1'b0;

  always #5 clk = ~clk;

  measure_scheduler #(
    .SETTLE_CYCLES(SC),
    .WIN_CYCLES   (WC),
    .AVG_LOG2     (AL),
    .GAP_CYCLES   (GC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .count_in    (count_in),
    .tx_busy     (tx_busy),
    .ro_en       (ro_en),
    .cnt_clr     (cnt_clr),
    .tx_start    (tx_start),
    .result      (result),
    .result_valid(result_valid),
    .sat         (sat),
    .busy        (busy)
  );

  task automatic test_reset();
    rst = 1'b0; run = 1'b0; tx_busy = 1'b0; count_in = 8'h00;
    #1;
    vec++;
    if ({ro_en, cnt_clr, tx_start, result_valid, sat, busy, result} !== 14'h0) begin
      $display("FAIL reset_async got %b exp 0", {ro_en, cnt_clr, tx_start, result_valid, sat, busy, result});
      errs++;
    end
    repeat (2) @(negedge clk);
    vec++;
    if ({ro_en, cnt_clr, tx_start, result_valid, sat, busy, result} !== 14'h0) begin
      $display("FAIL reset_held got %b exp 0", {ro_en, cnt_clr, tx_start, result_valid, sat, busy, result});
      errs++;
    end
    rst = 1'b1;
    @(negedge clk);
    vec++;
    if ({ro_en, busy} !== 2'b00) begin
      $display("FAIL reset_idle got %b exp 00", {ro_en, busy});
      errs++;
    end
  endtask

  // stop: 0 = run stays high, 1 = run dropped in SEND, 2 = run dropped in WAIT_TX
  task automatic test_burst(input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2,
                            input logic [7:0] v3, input int k, input int hold, input int stop,
                            input string tag);
    logic [7:0] v[4];
    int         exp_res;
    logic       exp_sat;
    logic       exp_clr;
    v       = '{v0, v1, v2, v3};
    exp_res = (int'(v0) + int'(v1) + int'(v2) + int'(v3)) / NW;
    exp_sat = (v0 == 8'hFF) || (v1 == 8'hFF) || (v2 == 8'hFF) || (v3 == 8'hFF);
    tx_busy  = (k == 0);
    count_in = 8'($urandom);
    run      = 1'b1;
    for (int c = 1; c <= SC + NW * WC; c++) begin
      @(negedge clk);
      exp_clr = (c >= SC + 1) && (((c - SC - 1) % WC) == 0);
      vec++;
      if ({ro_en, busy, tx_start, result_valid} !== 4'b1100) begin
        $display("FAIL %s ctl c=%0d got %b exp 1100", tag, c, {ro_en, busy, tx_start, result_valid});
        errs++;
      end
      vec++;
      if (cnt_clr !== exp_clr) begin
        $display("FAIL %s cnt_clr c=%0d got %b exp %b", tag, c, cnt_clr, exp_clr);
        errs++;
      end
      if (c > SC && ((c - SC) % WC) == 0) count_in = v[(c - SC) / WC - 1];
      else count_in = 8'($urandom);
    end
    @(negedge clk);
    vec++;
    if ({ro_en, cnt_clr, result_valid, tx_start, busy} !== 5'b00111) begin
      $display("FAIL %s done_ctl got %b exp 00111", tag, {ro_en, cnt_clr, result_valid, tx_start, busy});
      errs++;
    end
    vec++;
    if (result !== 8'(exp_res)) begin
      $display("FAIL %s result got %0d exp %0d", tag, result, exp_res);
      errs++;
    end
    vec++;
    if (sat !== exp_sat) begin
      $display("FAIL %s sat got %b exp %b", tag, sat, exp_sat);
      errs++;
    end
    m_result = 8'(exp_res);
    m_sat    = exp_sat;
    if (stop == 1) run = 1'b0;
    for (int i = 1; i < k; i++) begin
      @(negedge clk);
      vec++;
      if ({tx_start, result_valid} !== 2'b10) begin
        $display("FAIL %s tx_hold i=%0d got %b exp 10", tag, i, {tx_start, result_valid});
        errs++;
      end
    end
    if (k > 0) tx_busy = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      vec++;
      if ({tx_start, ro_en, busy} !== 3'b001) begin
        $display("FAIL %s wait_tx i=%0d got %b exp 001", tag, i, {tx_start, ro_en, busy});
        errs++;
      end
      if (stop == 2 && i == hold / 2) run = 1'b0;
    end
    tx_busy = 1'b0;
    if (stop != 0) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        vec++;
        if ({busy, ro_en, tx_start} !== 3'b000) begin
          $display("FAIL %s stop_idle i=%0d got %b exp 000", tag, i, {busy, ro_en, tx_start});
          errs++;
        end
      end
    end else begin
      for (int i = 0; i < GC; i++) begin
        @(negedge clk);
        vec++;
        if ({ro_en, busy, tx_start} !== 3'b010) begin
          $display("FAIL %s gap i=%0d got %b exp 010", tag, i, {ro_en, busy, tx_start});
          errs++;
        end
      end
      @(negedge clk);
      vec++;
      if ({ro_en, busy, cnt_clr} !== 3'b110) begin
        $display("FAIL %s resettle got %b exp 110", tag, {ro_en, busy, cnt_clr});
        errs++;
      end
      run = 1'b0;
      @(negedge clk);
      vec++;
      if ({ro_en, busy, result} !== {2'b00, m_result}) begin
        $display("FAIL %s settle_abort got %b exp %b", tag, {ro_en, busy, result}, {2'b00, m_result});
        errs++;
      end
    end
  endtask

  task automatic test_abort_measure(input int d);
    run = 1'b1;
    for (int c = 1; c <= SC + WC + d; c++) begin
      @(negedge clk);
      count_in = 8'($urandom);
    end
    run = 1'b0;
    @(negedge clk);
    vec++;
    if ({ro_en, busy, cnt_clr, tx_start, result_valid} !== 5'b00000) begin
      $display("FAIL abort_ctl got %b exp 00000", {ro_en, busy, cnt_clr, tx_start, result_valid});
      errs++;
    end
    vec++;
    if ({result, sat} !== {m_result, m_sat}) begin
      $display("FAIL abort_keep got %h/%b exp %h/%b", result, sat, m_result, m_sat);
      errs++;
    end
    for (int i = 0; i < 2 * WC; i++) begin
      @(negedge clk);
      vec++;
      if ({tx_start, ro_en, result_valid} !== 3'b000) begin
        $display("FAIL abort_quiet i=%0d got %b exp 000", i, {tx_start, ro_en, result_valid});
        errs++;
      end
    end
  endtask

  task automatic test_reset_mid();
    run = 1'b1;
    for (int c = 1; c <= SC + 3; c++) @(negedge clk);
    rst = 1'b0;
    #1;
    vec++;
    if ({ro_en, cnt_clr, tx_start, result_valid, sat, busy, result} !== 14'h0) begin
      $display("FAIL rst_mid_async got %b exp 0", {ro_en, cnt_clr, tx_start, result_valid, sat, busy, result});
      errs++;
    end
    m_result = 8'h00;
    m_sat    = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vec++;
    if ({ro_en, busy, tx_start} !== 3'b110) begin
      $display("FAIL rst_mid_settle got %b exp 110", {ro_en, busy, tx_start});
      errs++;
    end
    for (int c = 2; c <= SC + NW * WC; c++) begin
      @(negedge clk);
      vec++;
      if ({tx_start, result_valid} !== 2'b00) begin
        $display("FAIL rst_mid_notx c=%0d got %b exp 00", c, {tx_start, result_valid});
        errs++;
      end
    end
    run = 1'b0;
    @(negedge clk);
    vec++;
    if ({busy, tx_start, result} !== 10'h0) begin
      $display("FAIL rst_mid_idle got %b exp 0", {busy, tx_start, result});
      errs++;
    end
  endtask

  initial begin
    test_reset();
    test_burst(8'd10, 8'd20, 8'd30, 8'd41, 2, 20, 0, "avg_basic");
    test_burst(8'd0, 8'd255, 8'd0, 8'd0, 1, 3, 0, "sat_one");
    test_burst(8'd255, 8'd255, 8'd255, 8'd255, 0, 2, 0, "all_max");
    test_abort_measure(3);
    test_burst(8'd7, 8'd9, 8'd200, 8'd1, 2, 5, 2, "stop_wait_tx");
    test_burst(8'd3, 8'd4, 8'd5, 8'd6, 3, 2, 1, "stop_send");
    for (int n = 0; n < 8; n++) begin
      logic [7:0] r[4];
      for (int j = 0; j < 4; j++) r[j] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      test_burst(r[0], r[1], r[2], r[3], int'($urandom_range(0, 3)), int'($urandom_range(1, 6)),
                 int'($urandom_range(0, 2)), "random");
      if (n == 4) test_abort_measure(int'($urandom_range(1, WC)));
    end
    test_reset_mid();
    test_burst(8'd100, 8'd101, 8'd102, 8'd103, 1, 1, 0, "post_reset");
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/measure_scheduler.md
MEASURE_SCHEDULER -- requirements
Module: measure_scheduler

Interface
REQ-001 SHALL provide parameter SETTLE_CYCLES, default 16: cycles the oscillator runs before each burst, to let it stabilise.
REQ-002 SHALL provide parameter WIN_CYCLES, default 256: length in clk cycles of one counting window.
REQ-003 SHALL provide parameter AVG_LOG2, default 2: each burst holds 2^AVG_LOG2 windows, averaged into one result.
REQ-004 SHALL provide parameter GAP_CYCLES, default 64: cycles the oscillator is held off between bursts.
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 run  input  1  level: 1 = keep scheduling measurement bursts.
REQ-008 count_in  input  8  current edge-counter value.
REQ-009 tx_busy  input  1  UART busy flag.
REQ-010 ro_en  output  1  enable for the oscillator, synchroniser, edge detector and counter chain.
REQ-011 cnt_clr  output  1  one-cycle pulse that clears the edge counter.
REQ-012 tx_start  output  1  UART start request.
REQ-013 result  output  8  averaged count of the last burst.
REQ-014 result_valid  output  1  one-cycle pulse when result updates.
REQ-015 sat  output  1  set if any window in the last burst captured count_in == 8'hFF.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, SETTLE, MEASURE, SEND, WAIT_TX and GAP.
REQ-018 ro_en SHALL be 1 in SETTLE and MEASURE only.
REQ-019 IDLE: when run == 1, go to SETTLE and load the cycle counter with SETTLE_CYCLES-1.
REQ-020 SETTLE: decrement the cycle counter; at 0, go to MEASURE, pulse cnt_clr, clear the accumulator, sample index and sat_acc, and load WIN_CYCLES-1.
REQ-021 MEASURE: decrement the cycle counter; at 0, add count_in (zero-extended) into the 8+AVG_LOG2-bit accumulator and OR (count_in == 8'hFF) into sat_acc.
REQ-022 At the end of a window with sample index < 2^AVG_LOG2-1: increment the index, pulse cnt_clr, reload WIN_CYCLES-1 and stay in MEASURE, with no dead cycle between windows.
REQ-023 At the end of the last window (captured value included): result <= (acc+count_in) >> AVG_LOG2, truncated (no rounding); sat <= final sat_acc; result_valid pulses; go to SEND.
REQ-024 The accumulator SHALL never overflow, since its width is 8+AVG_LOG2.
REQ-025 SEND: hold tx_start = 1 until tx_busy == 1 is sampled, then drop tx_start and go to WAIT_TX.
REQ-026 WAIT_TX: when tx_busy == 0 is sampled, go to GAP and load GAP_CYCLES-1.
REQ-027 GAP: decrement; at 0, go to SETTLE if run == 1, else IDLE.
REQ-028 run deasserted in SETTLE, MEASURE or GAP: go to IDLE on the next edge, drop ro_en, discard the partial accumulation, and leave result, sat and tx_start unchanged.
REQ-029 run deasserted in SEND or WAIT_TX: the current transmission SHALL complete, then go to IDLE (GAP skipped).
REQ-030 tx_busy already 1 on SEND entry: tx_start SHALL still assert for at least one cycle, then the block moves to WAIT_TX.
REQ-031 A parameter value of 1 for SETTLE_CYCLES, WIN_CYCLES or GAP_CYCLES SHALL give a 1-cycle state; values of 0 are illegal.

Reset
REQ-032 On rst low, immediately: state = IDLE; ro_en, cnt_clr, tx_start, result_valid, sat and busy = 0; result = 8'h00; all counters and the accumulator = 0.
REQ-033 Reset released mid-burst: the block restarts from IDLE and issues no tx_start for the aborted burst.

Verification
REQ-034 Test parameters SETTLE_CYCLES=4, WIN_CYCLES=8, AVG_LOG2=2, GAP_CYCLES=3; run=1; count_in = 10, 20, 30, 41 at the four window ends -> result = 25, sat = 0, result_valid pulses once, tx_start rises in the next cycle.
REQ-035 Same setup, one window ends with count_in = 255 and the others 0 -> result = 63, sat = 1.
REQ-036 tx_busy asserted 2 cycles after tx_start and held for 20 cycles -> tx_start lasts exactly 2 cycles; GAP (ro_en = 0 for 3 cycles) starts after tx_busy falls; the next SETTLE follows.
REQ-037 run dropped during the 2nd window -> ro_en = 0 on the next cycle, state IDLE, result keeps its old value, no tx_start.
REQ-038 run dropped during WAIT_TX -> the transmission completes, then IDLE with no GAP.
REQ-039 rst pulsed low during MEASURE -> all outputs reach their reset values asynchronously (before the next clk edge); after release with run = 1, SETTLE begins one cycle later.
